// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared UART RX encodings and defaults
package uart_rx_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    localparam logic [2:0] IDLE_ENC   = 3'd0;
    localparam logic [2:0] START_ENC  = 3'd1;
    localparam logic [2:0] DATA_ENC   = 3'd2;
    localparam logic [2:0] PARITY_ENC = 3'd3;
    localparam logic [2:0] STOP_ENC   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = IDLE_ENC,
        START  = START_ENC,
        DATA   = DATA_ENC,
        PARITY = PARITY_ENC,
        STOP   = STOP_ENC
    } rx_state_t;

endpackage

// File: rtl/rx_parity_calc.sv
// rtl/rx_parity_calc.sv - expected parity bit for a data word
module rx_parity_calc
    import uart_rx_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    input  logic             par_typ,
    output logic             parity_bit
);

    logic data_xor;

    // even parity sends XOR of the data, odd parity sends its inverse
    always_comb begin
        data_xor   = ^data;
        parity_bit = (par_typ == PAR_ODD) ? ~data_xor : data_xor;
    end

endmodule

// File: rtl/rx_frame_deserializer.sv
// rtl/rx_frame_deserializer.sv - UART RX frame FSM: start/data/parity/stop checking
module rx_frame_deserializer
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  frame_start,
    input  logic                  sample_done,
    input  logic                  sampled_bit,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  start_error,
    output logic                  busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    rx_state_t             state;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_bad;
    logic                  exp_parity;

    // expected parity over the fully assembled word (valid once in PARITY)
    rx_parity_calc #(
        .WIDTH (DATA_WIDTH)
    ) u_parity_calc (
        .data       (shift_reg),
        .par_typ    (par_typ_q),
        .parity_bit (exp_parity)
    );

    // busy is a pure decode of the state register so it tracks state with no lag
    assign busy = (state != IDLE);

    // frame FSM with registered one-cycle status pulses
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            bit_idx      <= '0;
            shift_reg    <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_bad      <= 1'b0;
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            start_error  <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            start_error  <= 1'b0;
            case (state)
                IDLE: begin
                    // strobes are ignored here; only a start edge opens a frame
                    if (frame_start) begin
                        state     <= START;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                    end
                end
                START: begin
                    if (sample_done) begin
                        if (!sampled_bit) begin
                            state   <= DATA;
                            bit_idx <= '0;
                            par_bad <= 1'b0;
                        end else begin
                            start_error <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (sample_done) begin
                        shift_reg[bit_idx] <= sampled_bit;
                        // hold the index on the last bit instead of wrapping
                        if (bit_idx == LAST_IDX) begin
                            state <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (sample_done) begin
                        par_bad <= sampled_bit ^ exp_parity;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (sample_done) begin
                        stop_error   <= ~sampled_bit;
                        parity_error <= par_bad;
                        if (sampled_bit && !par_bad) begin
                            P_DATA     <= shift_reg;
                            data_valid <= 1'b1;
                        end
                        // a start edge on the stop strobe chains straight into the next frame
                        if (frame_start) begin
                            state     <= START;
                            par_en_q  <= PAR_EN;
                            par_typ_q <= PAR_TYP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_deserializer.sv
// tb/tb_rx_frame_deserializer.sv - directed self-checking bench for rx_frame_deserializer
module tb_rx_frame_deserializer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       frame_start = 1'b0;
    logic       sample_done = 1'b0;
    logic       sampled_bit = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;
    logic       start_error;
    logic       busy;

    int total = 0;
    int bad   = 0;

    rx_frame_deserializer #(.DATA_WIDTH(8)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .frame_start  (frame_start),
        .sample_done  (sample_done),
        .sampled_bit  (sampled_bit),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .P_DATA       (P_DATA),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .start_error  (start_error),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic [7:0] pd, input logic dv,
                             input logic pe, input logic se, input logic ste, input logic bz);
        chk({tag, ".P_DATA"}, {24'd0, P_DATA}, {24'd0, pd});
        chk({tag, ".data_valid"}, {31'd0, data_valid}, {31'd0, dv});
        chk({tag, ".parity_error"}, {31'd0, parity_error}, {31'd0, pe});
        chk({tag, ".stop_error"}, {31'd0, stop_error}, {31'd0, se});
        chk({tag, ".start_error"}, {31'd0, start_error}, {31'd0, ste});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, bz});
    endtask

    task automatic pulse_start();
        @(negedge CLK) frame_start = 1'b1;
        @(negedge CLK) frame_start = 1'b0;
    endtask

    task automatic strobe(input logic b);
        @(negedge CLK) begin sample_done = 1'b1; sampled_bit = b; end
        @(negedge CLK) sample_done = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] d);
        for (int i = 0; i < 8; i++) strobe(d[i]);
    endtask

    // start edge, start bit 0, data, optional parity, stop; returns on the cycle after stop
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                              input logic pbit, input logic sbit);
        PAR_EN  = pen;
        PAR_TYP = ptyp;
        pulse_start();
        strobe(1'b0);
        send_data(d);
        if (pen) strobe(pbit);
        strobe(sbit);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #12;
        chk_flags("reset", 8'h00, 0, 0, 0, 0, 0);
        @(negedge CLK) RST = 1'b1;

        // 1: 0xA5 without parity
        send_frame(8'hA5, 0, 0, 0, 1);
        chk_flags("t1", 8'hA5, 1, 0, 0, 0, 0);
        @(negedge CLK);
        chk({"t1.pulse_once"}, {31'd0, data_valid}, 32'd0);

        // 2: even parity, good then bad parity bit
        send_frame(8'h3C, 1, 0, 0, 1);
        chk_flags("t2a", 8'h3C, 1, 0, 0, 0, 0);
        send_frame(8'h3C, 1, 0, 1, 1);
        chk_flags("t2b", 8'h3C, 0, 1, 0, 0, 0);
        @(negedge CLK);
        chk("t2b.pe_once", {31'd0, parity_error}, 32'd0);

        // 3: odd parity on 0x01 expects parity bit 0; send 1 plus a bad stop bit
        send_frame(8'h01, 1, 1, 1, 0);
        chk_flags("t3a", 8'h3C, 0, 1, 1, 0, 0);
        send_frame(8'h01, 1, 1, 0, 0);
        chk_flags("t3b", 8'h3C, 0, 0, 1, 0, 0);

        // 4: glitched start bit, then a clean 0x55
        PAR_EN = 1'b0;
        pulse_start();
        chk("t4.busy_start", {31'd0, busy}, 32'd1);
        strobe(1'b1);
        chk_flags("t4a", 8'h3C, 0, 0, 0, 1, 0);
        @(negedge CLK);
        chk("t4.ste_once", {31'd0, start_error}, 32'd0);
        send_frame(8'h55, 0, 0, 0, 1);
        chk_flags("t4b", 8'h55, 1, 0, 0, 0, 0);

        // 5: reset mid-frame after the 4th data bit of 0xFF
        PAR_EN = 1'b0;
        pulse_start();
        strobe(1'b0);
        for (int i = 0; i < 4; i++) strobe(1'b1);
        chk("t5.busy_mid", {31'd0, busy}, 32'd1);
        @(negedge CLK) RST = 1'b0;
        #1;
        chk_flags("t5.rst", 8'h00, 0, 0, 0, 0, 0);
        @(negedge CLK) RST = 1'b1;
        send_frame(8'h81, 0, 0, 0, 1);
        chk_flags("t5.frame", 8'h81, 1, 0, 0, 0, 0);
        @(negedge CLK);
        chk("t5.dv_once", {31'd0, data_valid}, 32'd0);

        // 6: back-to-back frames, PAR_EN toggled mid-frame on the second
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
        pulse_start();
        strobe(1'b0);
        send_data(8'h12);
        @(negedge CLK) begin sample_done = 1'b1; sampled_bit = 1'b1; frame_start = 1'b1; end
        @(negedge CLK) begin sample_done = 1'b0; frame_start = 1'b0; end
        chk_flags("t6a", 8'h12, 1, 0, 0, 0, 1);
        strobe(1'b0);
        PAR_EN = 1'b1;
        send_data(8'h34);
        strobe(1'b1);
        chk_flags("t6b", 8'h34, 1, 0, 0, 0, 0);

        // strobe while idle has no effect
        strobe(1'b0);
        chk_flags("idle_strobe", 8'h34, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
